// File: rtl/imem_resp.sv
// Instruction memory with a byte-serial program loader.
// Fetches read combinationally in IDLE; a load streams little-endian bytes into words.
module imem_resp #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_dat_out,
  input  logic        ld_start,
  input  logic        ld_vld,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_rdy,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [15:0] ld_cnt,
  output logic [7:0]  misalign_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     part_q, part_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      mis_q, mis_d;
  logic            done_q, done_d;
  logic [31:0]     mem_q [DEPTH];

  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     merged;
  logic            in_range;

  assign merged   = part_q | ({24'b0, ld_byte} << {lane_q, 3'b000});
  assign in_range = (mem_addr[31:AW+2] == '0);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    lane_d  = lane_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    we      = 1'b0;
    wdata   = part_q;

    unique case (state_q)
      IDLE: begin
        if (mem_addr[1:0] != 2'b00 && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          lane_d  = '0;
          part_d  = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          wptr_d = '0;
          lane_d = '0;
          part_d = '0;
          cnt_d  = '0;
        end else if (ld_vld) begin
          if (lane_q == 2'd3) begin
            we     = 1'b1;
            wdata  = merged;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            part_d = '0;
            lane_d = '0;
            if (ld_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            part_d = merged;
            lane_d = lane_q + 2'd1;
            if (ld_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          lane_d  = '0;
          part_d  = '0;
          cnt_d   = '0;
        end else begin
          // Unfilled upper bytes are already zero: the partial word is cleared at every word boundary.
          we      = 1'b1;
          wdata   = part_q;
          wptr_d  = wptr_q + 1'b1;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          part_d  = '0;
          lane_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      lane_q  <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_WORD;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      lane_q  <= lane_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      if (we) mem_q[wptr_q] <= wdata;
    end
  end

  always_comb begin
    mem_dat_out = NOP_WORD;
    if (state_q == IDLE && mem_addr[1:0] == 2'b00 && in_range)
      mem_dat_out = mem_q[mem_addr[AW+1:2]];
  end

  assign ld_rdy       = (state_q == LOAD);
  assign ld_busy      = (state_q != IDLE);
  assign ld_done      = done_q;
  assign ld_cnt       = cnt_q;
  assign misalign_cnt = mis_q;

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: two instances (DEPTH 256 and 4) share one stimulus stream
// and are compared against a load-level reference model.
module tb_imem_resp;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        ld_start, ld_vld, ld_last;
  logic [7:0]  ld_byte;

  logic [31:0] b_dat, s_dat;
  logic        b_rdy, b_busy, b_done, s_rdy, s_busy, s_done;
  logic [15:0] b_cnt, s_cnt;
  logic [7:0]  b_mis, s_mis;

  always #5 clk = ~clk;

  imem_resp u_big (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_dat_out(b_dat),
    .ld_start(ld_start), .ld_vld(ld_vld), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_rdy(b_rdy), .ld_busy(b_busy), .ld_done(b_done), .ld_cnt(b_cnt), .misalign_cnt(b_mis)
  );

  imem_resp #(.DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_dat_out(s_dat),
    .ld_start(ld_start), .ld_vld(ld_vld), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_rdy(s_rdy), .ld_busy(s_busy), .ld_done(s_done), .ld_cnt(s_cnt), .misalign_cnt(s_mis)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory images, word count, misalign count, idle flag.
  logic [31:0] m_big [256];
  logic [31:0] m_small [4];
  int          m_cnt;
  int          m_mis;
  bit          m_idle;
  logic [7:0]  stim [$];
  logic [7:0]  sess [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input bit big);
    if (!m_idle || a[1:0] != 2'b00) return NOP;
    if (big) return ((a >> 2) < 32'd256) ? m_big[a[9:2]] : NOP;
    return ((a >> 2) < 32'd4) ? m_small[a[3:2]] : NOP;
  endfunction

  task automatic tick();
    if (m_idle && mem_addr[1:0] != 2'b00 && m_mis < 255) m_mis++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_bdat"},  b_dat, exp_rd(mem_addr, 1'b1));
    chk({tag, "_sdat"},  s_dat, exp_rd(mem_addr, 1'b0));
    chk({tag, "_bbusy"}, 32'(b_busy), 32'(!m_idle));
    chk({tag, "_sbusy"}, 32'(s_busy), 32'(!m_idle));
    chk({tag, "_bcnt"},  32'(b_cnt), 32'(m_cnt));
    chk({tag, "_scnt"},  32'(s_cnt), 32'(m_cnt));
    chk({tag, "_bmis"},  32'(b_mis), 32'(m_mis));
    chk({tag, "_smis"},  32'(s_mis), 32'(m_mis));
  endtask

  task automatic chk_done(input string tag, input logic exp);
    chk({tag, "_bdone"}, 32'(b_done), 32'(exp));
    chk({tag, "_sdone"}, 32'(s_done), 32'(exp));
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, "_brdy"}, 32'(b_rdy), 32'(exp));
    chk({tag, "_srdy"}, 32'(s_rdy), 32'(exp));
  endtask

  // Word w of a session is stored at w mod DEPTH; missing bytes read as zero.
  task automatic commit(input bit incl_partial);
    int nw;
    logic [31:0] word;
    nw = incl_partial ? (sess.size() + 3) / 4 : sess.size() / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < sess.size()) word[8*b +: 8] = sess[4*w + b];
      m_big[w % 256] = word;
      m_small[w % 4] = word;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ld_start = 1'b0; ld_vld = 1'b0; ld_last = 1'b0; ld_byte = '0; mem_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) m_big[i] = NOP;
    for (int i = 0; i < 4; i++) m_small[i] = NOP;
    m_cnt = 0; m_mis = 0; m_idle = 1'b1;
  endtask

  // Streams stim[0..n-1]; if rs>=0, ld_start is raised alongside byte rs and the stream replays from 0.
  task automatic run_load(input int n, input int rs, input bit bubbles);
    int i;
    int restart;
    restart = rs;
    ld_vld = 1'b0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0; m_idle = 1'b0; m_cnt = 0; sess.delete();
    check_outs("start"); chk_rdy("start", 1'b1);
    i = 0;
    while (i < n) begin
      mem_addr = $urandom;
      if (bubbles && $urandom_range(0, 3) == 0) begin
        ld_vld = 1'b0; ld_last = 1'($urandom);
        tick();
        check_outs("bub"); chk_rdy("bub", 1'b1);
        continue;
      end
      ld_vld = 1'b1; ld_byte = stim[i]; ld_last = (i == n - 1);
      if (i == restart) begin
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        commit(1'b0); sess.delete(); m_cnt = 0; restart = -1; i = 0;
        check_outs("rs"); chk_rdy("rs", 1'b1); chk_done("rs", 1'b0);
        continue;
      end
      tick();
      sess.push_back(stim[i]); i++;
      if (i < n) begin
        m_cnt = sess.size() / 4;
        check_outs("ld"); chk_rdy("ld", 1'b1); chk_done("ld", 1'b0);
      end
    end
    ld_vld = 1'b0; ld_last = 1'b0;
    if (sess.size() % 4 != 0) begin
      m_cnt = sess.size() / 4;
      check_outs("flush"); chk_rdy("flush", 1'b0); chk_done("flush", 1'b0);
      tick();
    end
    commit(1'b1); m_cnt = (sess.size() + 3) / 4; m_idle = 1'b1;
    check_outs("end"); chk_rdy("end", 1'b0); chk_done("end", 1'b1);
    tick();
    check_outs("post"); chk_done("post", 1'b0);
  endtask

  task automatic dump(input string tag);
    logic [31:0] extra [4];
    extra = '{32'h400, 32'h402, 32'hFFFF_FFFC, 32'h1};
    for (int a = 0; a < 8; a++) begin
      mem_addr = 32'(a * 4);
      tick();
      check_outs(tag);
    end
    for (int k = 0; k < 4; k++) begin
      mem_addr = extra[k];
      tick();
      check_outs(tag);
    end
  endtask

  initial begin
    do_reset();
    // Reset state
    check_outs("reset"); chk_rdy("reset", 1'b0); chk_done("reset", 1'b0);
    chk("reset_dat0", b_dat, 32'h00000013);

    // Misaligned idle fetches
    mem_addr = 32'h2;
    repeat (3) tick();
    chk("mis3", 32'(b_mis), 32'd3);
    check_outs("mis3");

    // Single aligned word
    stim = '{8'h93, 8'h00, 8'h50, 8'h00};
    run_load(4, -1, 1'b0);
    chk("w1_cnt", 32'(b_cnt), 32'd1);
    mem_addr = 32'h0;
    tick();
    chk("w1_dat", b_dat, 32'h00500093);
    dump("w1");

    // Partial final word goes through FLUSH
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(6, -1, 1'b0);
    chk("fl_cnt", 32'(b_cnt), 32'd2);
    mem_addr = 32'h0; tick(); chk("fl_w0", b_dat, 32'h04030201);
    mem_addr = 32'h4; tick(); chk("fl_w1", b_dat, 32'h00000605);
    dump("fl");

    // Restart after two accepted bytes
    stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load(4, 2, 1'b0);
    mem_addr = 32'h0; tick(); chk("rs_w0", b_dat, 32'hD4C3B2A1);
    dump("rs");

    // Twenty bytes wrap the small instance's pointer
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
    run_load(20, -1, 1'b0);
    chk("wrap_scnt", 32'(s_cnt), 32'd5);
    mem_addr = 32'h0; tick();
    chk("wrap_s0", s_dat, {stim[19], stim[18], stim[17], stim[16]});
    mem_addr = 32'h10; tick();
    chk("wrap_s10", s_dat, NOP);
    dump("wrap");

    // Reset in the middle of a load
    ld_start = 1'b1; tick(); ld_start = 1'b0; m_idle = 1'b0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      ld_vld = 1'b1; ld_byte = 8'(8'h70 + i); ld_last = 1'b0;
      tick();
    end
    do_reset();
    check_outs("mrst");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_done("mrst", 1'b0);
    end
    dump("mrst");

    // Byte traffic while idle is ignored
    for (int i = 0; i < 5; i++) begin
      ld_vld = 1'b1; ld_last = 1'($urandom); ld_byte = 8'($urandom); mem_addr = 32'(i * 4);
      tick();
      check_outs("idlevld"); chk_done("idlevld", 1'b0);
    end
    ld_vld = 1'b0; ld_last = 1'b0;

    // Randomized loads with bubbles and occasional restarts
    for (int t = 0; t < 8; t++) begin
      int n;
      int rs;
      n = $urandom_range(1, 24);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      rs = ($urandom_range(0, 9) < 3) ? $urandom_range(0, n - 1) : -1;
      run_load(n, rs, 1'b1);
      dump("rnd");
    end

    // Misalign counter saturates
    mem_addr = 32'h3;
    repeat (260) tick();
    check_outs("missat");
    chk("missat_b", 32'(b_mis), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction memory depth in 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the word returned whenever a fetch cannot be served.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset; synchronous and active-low.
REQ-005 SHALL have port mem_addr  input  32  meaning fetch byte address from the fetch stage.
REQ-006 SHALL have port mem_dat_out  output  32  meaning the fetched instruction word, combinational from mem_addr and current state.
REQ-007 SHALL have port ld_start  input  1  meaning a one-cycle request to begin a program load.
REQ-008 SHALL have port ld_vld  input  1  meaning ld_byte is valid.
REQ-009 SHALL have port ld_byte  input  8  meaning the program byte stream, little-endian within each word.
REQ-010 SHALL have port ld_last  input  1  meaning the accompanying byte is the final byte of the program.
REQ-011 SHALL have port ld_rdy  output  1  meaning the block accepts ld_byte this cycle.
REQ-012 SHALL have port ld_busy  output  1  meaning a load is in progress and fetches are served NOP_WORD.
REQ-013 SHALL have port ld_done  output  1  meaning a one-cycle pulse on load completion.
REQ-014 SHALL have port ld_cnt  output  16  meaning words written by the current or most recent load, saturating at 16'hFFFF.
REQ-015 SHALL have port misalign_cnt  output  8  meaning count of IDLE cycles with mem_addr[1:0]!=0, saturating at 8'hFF.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FLUSH; ld_busy=1 in LOAD and FLUSH; ld_rdy=1 only in LOAD.
REQ-017 SHALL, in IDLE, drive mem_dat_out = mem[mem_addr[AW+1:2]] (AW=log2 DEPTH) when mem_addr[1:0]==0 and mem_addr[31:2]<DEPTH, else NOP_WORD.
REQ-018 SHALL drive mem_dat_out = NOP_WORD in LOAD and FLUSH regardless of mem_addr.
REQ-019 SHALL increment misalign_cnt by 1 on each IDLE cycle with mem_addr[1:0]!=0, holding at 8'hFF.
REQ-020 SHALL, on ld_start in IDLE, enter LOAD next cycle with write pointer=0, byte lane=0, partial word=0, ld_cnt=0.
REQ-021 SHALL, on ld_start in LOAD or FLUSH, restart identically to REQ-020 (discard partial word, no write, no ld_done); ld_start overrides a same-cycle byte.
REQ-022 SHALL accept a byte on ld_vld&ld_rdy&!ld_start, placing it at bits [8*lane+7:8*lane] of the partial word; lane increments modulo 4.
REQ-023 SHALL, when the accepted byte has lane==3, write the assembled word to mem[wptr] at that edge, increment wptr (DEPTH-1 wraps to 0), and increment ld_cnt.
REQ-024 SHALL, on an accepted byte with ld_last=1 and lane==3, perform REQ-023 and return to IDLE.
REQ-025 SHALL, on an accepted byte with ld_last=1 and lane<3, enter FLUSH; in FLUSH, write the partial word with unfilled upper bytes zero, apply REQ-023 pointer/count updates, and return to IDLE after exactly one cycle.
REQ-026 SHALL pulse ld_done high for exactly the first IDLE cycle after LOAD or FLUSH completes; restart via ld_start SHALL NOT pulse ld_done.
REQ-027 SHALL ignore ld_vld in IDLE (no write, no state change); ld_last without ld_vld SHALL have no effect.
REQ-028 SHALL leave memory words not written by a load unchanged.
REQ-029 SHALL make a word written at edge N visible on mem_dat_out from cycle N+1 once IDLE.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, enter IDLE, set all memory words to NOP_WORD, wptr=0, lane=0, partial=0, ld_cnt=0, misalign_cnt=0, ld_done=0; ld_rdy=0, ld_busy=0.
REQ-031 SHALL, on reset mid-load, abandon the load with no further writes and no ld_done pulse.

Verification
REQ-032 SHALL cover: after reset, mem_addr=0x0 -> mem_dat_out=0x00000013; mem_addr=0x2 for 3 cycles -> misalign_cnt=3.
REQ-033 SHALL cover: ld_start, bytes 93,00,50,00 with last on 4th -> mem[0]=0x00500093, ld_cnt=1, ld_done one cycle; mem_addr=0x0 -> 0x00500093.
REQ-034 SHALL cover: 6 bytes 01..06, last on 6th -> FLUSH, mem[0]=0x04030201, mem[1]=0x00000605, ld_cnt=2.
REQ-035 SHALL cover: ld_start after 2 accepted bytes -> partial discarded, no write, next 4 bytes land in mem[0], single ld_done.
REQ-036 SHALL cover: DEPTH=4, load 20 bytes -> wptr wraps, mem[0] holds word 5, ld_cnt=5; mem_addr=0x10 -> NOP_WORD.
REQ-037 SHALL cover: rst_n=0 during LOAD after 3 bytes -> IDLE, memory all NOP_WORD, ld_done never asserted.
